fetch_sequencer: RTL and testbench

//  Multi-cycle instruction-fetch/PC-update controller for the 32-bit PC register.

---
 rtl/fetch_sequencer_pkg.sv | 24 ++
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_sequencer_mem_wait_timer.sv | 35 +++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// PC_in mux select codes and default parameter values.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_EXEC     = 3'd3,
    ST_UPDATE   = 3'd4,
    ST_INT_SAVE = 3'd5,
    ST_INT_VEC  = 3'd6,
    ST_FAULT    = 3'd7
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JMP  = 2'b10;
  localparam logic [1:0] SEL_VEC  = 2'b11;

  localparam logic [31:0] DEF_INT_VECTOR   = 32'h0000_03FC;
  localparam int          DEF_MEM_WAIT_MAX = 8;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the sequencer's memory, execute-unit and PC-register signals.
// master = the sequencer, slave = the surrounding datapath.
interface fetch_sequencer_if;
  logic        run;
  logic        mem_ready;
  logic        exec_done;
  logic        br_taken;
  logic        jump;
  logic        int_req;
  logic        int_en;
  logic        pc_ld;
  logic        pc_inc;
  logic [1:0]  pc_sel;
  logic [31:0] vec_addr;
  logic        mem_rd;
  logic        ir_ld;
  logic        epc_ld;
  logic        int_ack;
  logic        halt_fault;
  logic [2:0]  state_dbg;

  modport master (
    input  run, mem_ready, exec_done, br_taken, jump, int_req, int_en,
    output pc_ld, pc_inc, pc_sel, vec_addr, mem_rd, ir_ld, epc_ld, int_ack,
           halt_fault, state_dbg
  );

  modport slave (
    output run, mem_ready, exec_done, br_taken, jump, int_req, int_en,
    input  pc_ld, pc_inc, pc_sel, vec_addr, mem_rd, ir_ld, epc_ld, int_ack,
           halt_fault, state_dbg
  );
endinterface

// File: rtl/fetch_sequencer_mem_wait_timer.sv
// Counts memory-wait cycles; expired flags the cycle in which the
// MEM_WAIT_MAX-th consecutive non-ready cycle is being counted.
module fetch_sequencer_mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !clr && (cnt_q == CW'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch / PC-update controller: steps fetch, execute handshake,
// PC update and interrupt entry, with a sticky fault on memory timeout.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR   = DEF_INT_VECTOR,
  parameter int          MEM_WAIT_MAX = DEF_MEM_WAIT_MAX
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);
  state_e     state_q, state_d;
  logic       br_q, br_d;
  logic       jmp_q, jmp_d;
  logic       int_pend_q, int_pend_d;

  logic       timer_clr, timer_en, timer_expired;
  logic       pc_ld, pc_inc, mem_rd, ir_ld, epc_ld, int_ack, halt_fault;
  logic [1:0] pc_sel;

  fetch_sequencer_mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      br_q       <= 1'b0;
      jmp_q      <= 1'b0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      br_q       <= br_d;
      jmp_q      <= jmp_d;
      int_pend_q <= int_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    br_d       = br_q;
    jmp_d      = jmp_q;
    int_pend_d = int_pend_q;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_sel     = SEL_NONE;
    mem_rd     = 1'b0;
    ir_ld      = 1'b0;
    epc_ld     = 1'b0;
    int_ack    = 1'b0;
    halt_fault = 1'b0;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd    = 1'b1;
        timer_clr = 1'b1;
        state_d   = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        mem_rd = 1'b1;
        // Data arriving in the limit cycle still completes the fetch.
        if (bus.mem_ready) begin
          ir_ld   = 1'b1;
          state_d = ST_EXEC;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) state_d = ST_FAULT;
        end
      end
      ST_EXEC: begin
        if (bus.exec_done) begin
          br_d       = bus.br_taken;
          jmp_d      = bus.jump;
          int_pend_d = bus.int_req & bus.int_en;
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (jmp_q) begin
          pc_ld  = 1'b1;
          pc_sel = SEL_JMP;
        end else if (br_q) begin
          pc_ld  = 1'b1;
          pc_sel = SEL_BR;
        end else begin
          pc_inc = 1'b1;
        end
        if (int_pend_q)   state_d = ST_INT_SAVE;
        else if (bus.run) state_d = ST_FETCH;
        else              state_d = ST_IDLE;
      end
      ST_INT_SAVE: begin
        epc_ld  = 1'b1;
        state_d = ST_INT_VEC;
      end
      ST_INT_VEC: begin
        pc_ld   = 1'b1;
        pc_sel  = SEL_VEC;
        int_ack = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FAULT: begin
        halt_fault = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pc_ld      = pc_ld;
  assign bus.pc_inc     = pc_inc;
  assign bus.pc_sel     = pc_sel;
  assign bus.vec_addr   = INT_VECTOR;
  assign bus.mem_rd     = mem_rd;
  assign bus.ir_ld      = ir_ld;
  assign bus.epc_ld     = epc_ld;
  assign bus.int_ack    = int_ack;
  assign bus.halt_fault = halt_fault;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a reactive memory/execute driver
// predicts PC/EPC effects per instruction; a monitor checks every strobe.
module tb_fetch_sequencer;
  localparam logic [31:0] VEC = 32'h0000_03FC;
  localparam int          WMAX = 8;

  typedef struct {
    logic        ld;
    logic        inc;
    logic        epc;
    logic        ack;
    logic [1:0]  sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer #(.INT_VECTOR(VEC), .MEM_WAIT_MAX(WMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  bit          abort = 0;
  exp_t        sb[$];
  logic [31:0] model_pc = 32'h0;
  logic [31:0] br_tgt = 32'h0, jmp_tgt = 32'h0;
  logic [31:0] pc_reg, epc_reg, pc_in;

  // Environment PC/EPC registers and PC_in mux driven by the DUT strobes.
  always_comb begin
    case (bus.pc_sel)
      2'b01:   pc_in = br_tgt;
      2'b10:   pc_in = jmp_tgt;
      2'b11:   pc_in = bus.vec_addr;
      default: pc_in = 32'h0;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg  <= 32'h0;
      epc_reg <= 32'h0;
    end else begin
      if (bus.pc_ld)       pc_reg <= pc_in;
      else if (bus.pc_inc) pc_reg <= pc_reg + 32'd4;
      if (bus.epc_ld)      epc_reg <= pc_reg;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {22'h0, bus.pc_ld, bus.pc_inc, bus.pc_sel, bus.mem_rd, bus.ir_ld,
               bus.epc_ld, bus.int_ack, bus.halt_fault, bus.state_dbg}, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.br_taken = 1'($urandom);
    bus.jump     = 1'($urandom);
    bus.int_req  = 1'($urandom);
  endtask

  // Waits (bounded) for the first mem_rd cycle, i.e. the FETCH state.
  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.mem_rd) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    chk("fetch_timeout", 32'h0, 32'h1);
    abort = 1'b1;
  endtask

  task automatic run_instr(input int lat, input int elat, input bit br, input bit jmp,
                           input bit ireq, input bit ien, input bit run_after,
                           input logic [31:0] bt, input logic [31:0] jt, input bit rst_upd);
    bit   ok;
    exp_t e;
    wait_rd(ok);
    if (!ok) return;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < lat; i++) begin
      step();
      chk("wait_mem_rd", {31'h0, bus.mem_rd}, 32'h1);
      chk("wait_no_ir_ld", {31'h0, bus.ir_ld}, 32'h0);
    end
    step();
    bus.mem_ready = 1'b1;
    #1;
    chk("ir_ld_on_ready", {31'h0, bus.ir_ld}, 32'h1);
    step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < elat; i++) begin
      noise();
      step();
    end
    bus.exec_done = 1'b1;
    bus.br_taken  = br;
    bus.jump      = jmp;
    bus.int_req   = ireq;
    bus.int_en    = ien;
    bus.run       = run_after;
    br_tgt        = bt;
    jmp_tgt       = jt;
    // Reference: jump beats branch beats increment; interrupt entry follows.
    e.epc = 1'b0; e.ack = 1'b0;
    if (jmp)     begin e.ld = 1'b1; e.inc = 1'b0; e.sel = 2'b10; e.val = jt; end
    else if (br) begin e.ld = 1'b1; e.inc = 1'b0; e.sel = 2'b01; e.val = bt; end
    else         begin e.ld = 1'b0; e.inc = 1'b1; e.sel = 2'b00; e.val = model_pc + 32'd4; end
    model_pc = e.val;
    sb.push_back(e);
    if (ireq && ien) begin
      sb.push_back('{ld: 1'b0, inc: 1'b0, epc: 1'b1, ack: 1'b0, sel: 2'b00, val: model_pc});
      sb.push_back('{ld: 1'b1, inc: 1'b0, epc: 1'b0, ack: 1'b1, sel: 2'b11, val: VEC});
      model_pc = VEC;
    end
    step();
    bus.exec_done = 1'b0;
    noise();
    if (rst_upd) begin
      chk("upd_before_rst", {31'h0, bus.pc_ld | bus.pc_inc}, 32'h1);
      rst = 1'b1;
      sb.delete();
      model_pc = 32'h0;
      #1;
      chk_all_zero("rst_in_update");
      step();
      rst = 1'b0;
      #1;
      chk("idle_after_rst", {29'h0, bus.state_dbg}, 32'h0);
      return;
    end
    if (!(ireq && ien) && !run_after) begin
      step();
      chk("stop_idle", {29'h0, bus.state_dbg}, 32'h0);
      for (int i = 0; i < 3; i++) begin
        step();
        chk("stop_no_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
      end
      bus.run = 1'b1;
    end
  endtask

  // Monitor: every PC/EPC strobe cycle consumes one scoreboard entry.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (!rst && (bus.pc_ld || bus.pc_inc || bus.epc_ld || bus.int_ack)) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {28'h0, bus.pc_ld, bus.pc_inc, bus.epc_ld, bus.int_ack}, 32'h0);
        end else begin
          m = sb.pop_front();
          chk("strobes", {28'h0, bus.pc_ld, bus.pc_inc, bus.epc_ld, bus.int_ack},
              {28'h0, m.ld, m.inc, m.epc, m.ack});
          chk("pc_sel", {30'h0, bus.pc_sel}, {30'h0, m.sel});
          step();
          if (m.epc) chk("epc_value", epc_reg, m.val);
          else       chk("pc_value", pc_reg, m.val);
          $display("txn ld=%0b inc=%0b epc=%0b ack=%0b sel=%0d val=0x%0h pc=0x%0h epc_reg=0x%0h",
                   m.ld, m.inc, m.epc, m.ack, m.sel, m.val, pc_reg, epc_reg);
        end
      end
    end
  end

  initial begin
    bit ok;
    bus.run = 1'b0; bus.mem_ready = 1'b0; bus.exec_done = 1'b0;
    bus.br_taken = 1'b0; bus.jump = 1'b0; bus.int_req = 1'b0; bus.int_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    chk("reset_vec_addr", bus.vec_addr, VEC);
    step();
    rst = 1'b0;
    #1;
    chk("idle_after_reset", {29'h0, bus.state_dbg}, 32'h0);
    bus.run = 1'b1;

    run_instr(1, 0, 0, 0, 0, 0, 1, 32'h100, 32'h200, 0);  // PC 0 -> 4
    run_instr(0, 1, 1, 1, 0, 0, 1, 32'h100, 32'h00C, 0);  // jump beats branch
    run_instr(2, 0, 0, 0, 0, 1, 1, 32'h100, 32'h200, 0);  // PC -> 0x10
    run_instr(0, 2, 0, 0, 1, 1, 1, 32'h100, 32'h200, 0);  // interrupt at 0x10
    run_instr(WMAX - 1, 0, 1, 0, 1, 0, 1, 32'h440, 32'h200, 0);
    run_instr(3, 1, 0, 0, 0, 1, 0, 32'h100, 32'h200, 0);  // run dropped in EXEC
    run_instr(0, 0, 0, 0, 1, 1, 0, 32'h100, 32'h200, 0);  // interrupt overrides stop

    for (int n = 0; n < 40 && !abort; n++) begin
      run_instr(int'($urandom_range(0, WMAX - 1)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) != 0),
                32'($urandom_range(0, 4095)) << 2, 32'($urandom_range(0, 4095)) << 2, 0);
    end

    if (!abort) run_instr(1, 0, 0, 0, 0, 0, 1, 32'h100, 32'h200, 1);

    if (!abort) begin
      wait_rd(ok);
      if (ok) begin
        step();
        step();
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        bus.run = 1'b0;
        #1;
        chk_all_zero("rst_mid_wait_mem");
        step();
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("idle_after_mid_rst", {29'h0, bus.state_dbg}, 32'h0);
        step();
        chk("idle_hold_run0", {29'h0, bus.state_dbg}, 32'h0);
        bus.run = 1'b1;
      end
    end

    if (!abort) begin
      wait_rd(ok);
      if (ok) begin
        for (int i = 0; i < WMAX; i++) begin
          step();
          chk("timeout_wait_state", {29'h0, bus.state_dbg}, 32'h2);
          chk("timeout_no_fault_yet", {31'h0, bus.halt_fault}, 32'h0);
        end
        step();
        chk("fault_state", {29'h0, bus.state_dbg}, 32'h7);
        chk("fault_flag", {31'h0, bus.halt_fault}, 32'h1);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          step();
          chk("fault_sticky", {29'h0, bus.state_dbg}, 32'h7);
          chk("fault_quiet", {27'h0, bus.halt_fault, bus.mem_rd, bus.ir_ld, bus.pc_ld, bus.pc_inc},
              32'h10);
        end
      end
    end

    repeat (4) step();
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
